bram_port_arbiter: RTL
======================

# bram_port_arbiter

Two-channel access scheduler placed directly in front of the `dualport` true-dual-port BRAM (1024 x 16). It accepts one request stream per BRAM port and passes non-colliding accesses straight through. It detects same-address collisions in which at least one side writes, and serializes them with round-robin priority so the BRAM never sees an undefined read-during-write or write-write on one address. It also tracks read latency and returns read data with a valid strobe per channel.

## Interface
Parameters:
- `ADDR_W`, 10, address width; matches BRAM depth 1024.
- `DATA_W`, 16, data width.
- `RD_LAT`, 1, BRAM read latency in cycles, legal range 1..4.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `a_req`, `b_req`  in  1  channel request.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  ADDR_W  request address.
- `a_wdata`, `b_wdata`  in  DATA_W  write data.
- `a_gnt`, `b_gnt`  out  1  request accepted this cycle.
- `a_rvalid`, `b_rvalid`  out  1  read data valid.
- `a_rdata`, `b_rdata`  out  DATA_W  read data.
- `wrena`, `rdena`, `addra`, `dina`  out  1/1/ADDR_W/DATA_W  BRAM port A controls.
- `wrenb`, `rdenb`, `addrb`, `dinb`  out  1/1/ADDR_W/DATA_W  BRAM port B controls.
- `douta`, `doutb`  in  DATA_W  BRAM read data.
- `conflict_cnt`  out  16  collision counter (see Configuration).

## Operation
- Channel A always drives BRAM port A. Channel B always drives BRAM port B.
- Conflict occurs when `a_req & b_req & (a_addr == b_addr) & (a_we | b_we)`. Read-read on the same address is not a conflict.
- No conflict: each requesting channel gets `gnt` = `req` in the same cycle.
- Conflict: only the priority holder is granted. The loser sees `gnt` = 0 and must hold req/we/addr/wdata stable until granted.
- Priority register `prio`:
  - 0 means A wins, 1 means B wins.
  - After a conflict cycle, `prio` moves to the loser.
  - It is unchanged on non-conflict cycles.
  - Reset value is 0.
- BRAM enables are driven only for granted channels: `wrenX = X_gnt & X_we`, `rdenX = X_gnt & ~X_we`. Addresses and data pass through unconditionally.
- Read return:
  - Per channel, an RD_LAT-deep shift register carries `rdenX`.
  - `X_rvalid` is the last stage.
  - `X_rdata = doutX` whenever `X_rvalid` = 1. Otherwise `X_rdata` holds its last valid value (registered capture).
- Back-to-back reads are fully pipelined; one read per channel per cycle.

## Timing
- Grant path is combinational, from req/addr/we and `prio`; zero-cycle latency.
- A BRAM access is issued on the rising edge that ends the grant cycle.
- `X_rvalid` asserts exactly RD_LAT cycles after that edge, for one cycle per granted read.
- A losing request is granted on the next cycle if it is still held; worst-case wait is 1 cycle.
- While `rst_n` = 0:
  - `a_gnt`, `b_gnt` are forced to 0, so all BRAM enables are 0.
  - rvalid pipelines clear; `a_rvalid` = `b_rvalid` = 0.
  - `a_rdata` = `b_rdata` = 0.
  - `prio` = 0, `conflict_cnt` = 0.
- Reset mid-operation: in-flight reads are dropped with no rvalid. A request held across reset release is re-arbitrated on the first cycle with `rst_n` = 1.

## Configuration
- `BRAM_ARB_STATS_EN` defined: `conflict_cnt` increments by 1 on every conflict cycle and saturates at 16'hFFFF.
- Not defined: `conflict_cnt` is tied to 0 and the counter is not synthesized. Arbitration behaviour is identical in both cases.

## Test plan
- Independent traffic: A writes 16'h00FF @1 while B writes 16'h00BB @0 -> both gnt=1 same cycle. Later reads of @1 and @0 return 16'h00FF and 16'h00BB with rvalid 1 cycle after grant.
- Write-write collision at reset priority: A writes 16'h0066 @5 and B writes 16'h0077 @5, both held -> cycle 1: a_gnt=1, b_gnt=0. Cycle 2: b_gnt=1. Read @5 returns 16'h0077; `conflict_cnt`=1 with macro, 0 without.
- Alternation: repeat the same collision twice more -> winners B then A (`prio` toggles each conflict); `conflict_cnt`=3 with macro.
- Read-write collision: A writes 16'h0066 @6 while B reads @6 with `prio`=1 -> B granted first and returns the old value. Then A writes. A following B read @6 returns 16'h0066.
- Read-read same address @7 -> both granted same cycle, no count increment, both rdata equal.
- Reset mid-read: grant a read on A, drop `rst_n` on the next cycle -> `a_rvalid` never asserts and all outputs are 0. After release, `prio`=0 and a new collision is won by A.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-channel scheduler in front of a true-dual-port BRAM: passes disjoint accesses, serializes
// same-address collisions round-robin, tracks read latency. BRAM_ARB_STATS_EN enables conflict_cnt.
module bram_rd_lane #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rden,
  input  logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic [RD_LAT:1]    vld_pipe;
  logic [DATA_W-1:0]  hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      hold_q   <= '0;
    end else begin
      vld_pipe[1] <= rden;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (rvalid) hold_q <= dout;
    end
  end

  // Gated by rst_n so reset clears outputs in the same cycle, not one edge later.
  assign rvalid = rst_n & vld_pipe[RD_LAT];
  assign rdata  = !rst_n ? '0 : (rvalid ? dout : hold_q);
endmodule

module bram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              wrena,
  output logic              rdena,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              wrenb,
  output logic              rdenb,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dinb,
  input  logic [DATA_W-1:0] douta,
  input  logic [DATA_W-1:0] doutb,
  output logic [15:0]       conflict_cnt
);
  localparam int NUM_LANES = 2;

  logic prio;
  logic conflict;
  logic [NUM_LANES-1:0]             rden, rvalid;
  logic [NUM_LANES-1:0][DATA_W-1:0] dout, rdata;

  assign conflict = a_req & b_req & (a_addr == b_addr) & (a_we | b_we);
  assign a_gnt    = rst_n & a_req & (~conflict | ~prio);
  assign b_gnt    = rst_n & b_req & (~conflict |  prio);

  assign wrena = a_gnt & a_we;
  assign rdena = a_gnt & ~a_we;
  assign wrenb = b_gnt & b_we;
  assign rdenb = b_gnt & ~b_we;
  assign addra = a_addr;
  assign dina  = a_wdata;
  assign addrb = b_addr;
  assign dinb  = b_wdata;

  // Priority flips to the loser after every collision cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)        prio <= 1'b0;
    else if (conflict) prio <= ~prio;
  end

  assign rden = {rdenb, rdena};
  assign dout = {doutb, douta};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bram_rd_lane #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .rden   (rden[l]),
      .dout   (dout[l]),
      .rvalid (rvalid[l]),
      .rdata  (rdata[l])
    );
  end

  assign a_rvalid = rvalid[0];
  assign b_rvalid = rvalid[1];
  assign a_rdata  = rdata[0];
  assign b_rdata  = rdata[1];

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                             cnt_q <= '0;
    else if (conflict && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign conflict_cnt = rst_n ? cnt_q : 16'h0000;
`else
  assign conflict_cnt = 16'h0000;
`endif
endmodule
